cmp_stat_collector: RTL
=======================

CMP_STAT_COLLECTOR -- requirements
Module: cmp_stat_collector

Interface
REQ-001 SHALL have parameter WIN, default 16, meaning accepted samples per report window (legal range 2..255).
REQ-002 SHALL have parameter RUN_THRESH, default 4, meaning run length that raises run_alert (legal range 2..WIN).
REQ-003 SHALL have parameter CW, default 8, meaning report counter width; WIN <= 2^CW-1.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  comparator result present this cycle.
REQ-007 equal  input  1  comparator result: a==b.
REQ-008 greater  input  1  comparator result: a>b.
REQ-009 lesser  input  1  comparator result: a<b.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 rpt_valid  output  1  report fields valid.
REQ-012 rpt_ready  input  1  consumer takes report.
REQ-013 rpt_eq, rpt_gt, rpt_lt, rpt_err  output  CW each  per-window counts of equal, greater, lesser, illegal samples.
REQ-014 run_alert  output  1  one-cycle pulse when a run reaches RUN_THRESH.
REQ-015 run_class  output  2  class of current run: 00 none, 01 equal, 10 greater, 11 lesser.

Function
REQ-016 Sample accepted on rising edge when in_valid && in_ready; no other cycle changes counters or run state.
REQ-017 Legal sample: exactly one of equal/greater/lesser set; any other combination (000, two or three set) is illegal.
REQ-018 Legal sample increments its class counter by 1; illegal sample increments only the error counter.
REQ-019 FSM states COLLECT and REPORT; reset state COLLECT.
REQ-020 COLLECT: in_ready=1, rpt_valid=0; sample counter counts every accepted sample, legal or illegal.
REQ-021 Accepting sample number WIN: that sample's contribution included, the four counts copied to rpt_* registers, FSM -> REPORT next cycle.
REQ-022 REPORT: in_ready=0, rpt_valid=1, rpt_* held stable until rpt_ready sampled high.
REQ-023 REPORT with rpt_ready=1: working counters and sample counter cleared, FSM -> COLLECT next cycle; in_ready=1 from that cycle.
REQ-024 rpt_ready ignored in COLLECT; in_valid ignored in REPORT (no sample lost: producer sees in_ready=0).
REQ-025 Run tracking: legal sample of same class as run_class -> run length +1, saturating at WIN; different class or run_class=00 -> run length=1, run_class=sample class.
REQ-026 Illegal sample: run length=0, run_class=00.
REQ-027 run_alert SHALL be 1 exactly the cycle after the accepting edge where run length becomes RUN_THRESH; no re-fire while the run continues beyond it.
REQ-028 Run length and run_class cleared when REPORT->COLLECT transition occurs; runs do not span windows.
REQ-029 rpt_eq+rpt_gt+rpt_lt+rpt_err SHALL equal WIN for every report.
REQ-030 Single accepted sample per cycle; latency from sample WIN acceptance to rpt_valid=1 is 1 cycle.

Reset
REQ-031 rst_n low SHALL immediately force: FSM COLLECT, in_ready=1 (after reset release), rpt_valid=0, rpt_*=0, run_alert=0, run_class=00, all internal counters 0.
REQ-032 Reset asserted mid-window or during REPORT SHALL discard partial counts and pending report; no report emitted for that window.

Verification
REQ-033 16 samples equal=1, in_valid=1, rpt_ready=1 -> rpt_valid 1 cycle after 16th, rpt_eq=16, others 0; run_alert pulses once after 4th sample.
REQ-034 Pattern E,G,L repeating for 16 samples -> rpt_eq=6, rpt_gt=5, rpt_lt=5, rpt_err=0, run_alert never asserted.
REQ-035 G,G,G,illegal(110),G,G,G,G then 8 L -> run_alert after 8th sample (4th G after reset of run) and after 12th (4th L); rpt_err=1, rpt_gt=7, rpt_lt=8.
REQ-036 Window complete, rpt_ready held 0 for 10 cycles with in_valid=1 -> in_ready=0, rpt_* stable 10 cycles; rpt_ready=1 -> next cycle in_ready=1, counts restart at 0.
REQ-037 rst_n pulled low after 7 samples and in REPORT -> outputs zero asynchronously; after release 16 fresh samples produce report with no carried counts.
REQ-038 in_valid toggling every other cycle, 16 accepted samples of 000 -> rpt_err=16, run_class stays 00, run_alert never asserted.

Source files
------------

// File: rtl/cmp_stat_collector.sv
// -----------------------------------------------------------------------------
// cmp_stat_collector
//
// Collects statistics over windows of WIN accepted comparator results.
// Each accepted sample is classified as equal, greater, lesser or illegal (not
// exactly one flag set). The four per-class counts go into the report
// registers when the window's last sample is accepted. The block then
// presents the report and stalls input until the consumer takes it.
// Alongside the counts it tracks the current run of same-class legal samples
// and pulses run_alert once when a run reaches RUN_THRESH.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : comparator result present this cycle
//   equal      : result a==b
//   greater    : result a>b
//   lesser     : result a<b
//   in_ready   : block accepts a sample this cycle (high while collecting)
//   rpt_valid  : report fields valid (high while presenting a report)
//   rpt_ready  : consumer takes the report
//   rpt_eq/gt/lt/err : per-window counts of equal/greater/lesser/illegal
//   run_alert  : one-cycle pulse when a run reaches RUN_THRESH
//   run_class  : class of current run (00 none, 01 eq, 10 gt, 11 lt)
// -----------------------------------------------------------------------------
module cmp_stat_collector #(
    parameter int WIN        = 16,
    parameter int RUN_THRESH = 4,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          equal,
    input  logic          greater,
    input  logic          lesser,
    output logic          in_ready,
    output logic          rpt_valid,
    input  logic          rpt_ready,
    output logic [CW-1:0] rpt_eq,
    output logic [CW-1:0] rpt_gt,
    output logic [CW-1:0] rpt_lt,
    output logic [CW-1:0] rpt_err,
    output logic          run_alert,
    output logic [1:0]    run_class
);

    localparam logic [CW-1:0] WIN_C = CW'(WIN);
    localparam logic [CW-1:0] RT_C  = CW'(RUN_THRESH);

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    state_t        state_q, state_d;

    logic          legal;
    logic [1:0]    smp_class;
    logic [3:0]    hit;          // {err, lt, gt, eq}
    logic          accept;
    logic          last;
    logic          release_rpt;

    logic [CW-1:0] smp_q, smp_d;
    logic [CW-1:0] run_len_q, run_len_d;
    logic [1:0]    run_class_q, run_class_d;
    logic          run_alert_q, run_alert_d;

    // Report registers from the per-class generate slices, packed eq,gt,lt,err
    logic [4*CW-1:0] rpt_flat;

    // ------------------------------------------------------------------
    // Sample classification
    // ------------------------------------------------------------------
    always_comb begin
        // Exactly one flag set: odd parity rules out 0 and 2 set, the AND
        // rules out all three.
        legal     = (equal ^ greater ^ lesser) && !(equal && greater && lesser);
        smp_class = 2'b00;
        if (legal) begin
            if (equal)        smp_class = 2'b01;
            else if (greater) smp_class = 2'b10;
            else              smp_class = 2'b11;
        end
        hit = {~legal, legal & lesser, legal & greater, legal & equal};
    end

    assign accept      = in_valid && (state_q == COLLECT);
    assign last        = (smp_q == WIN_C - 1'b1);
    assign release_rpt = (state_q == REPORT) && rpt_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && last) state_d = REPORT;
            REPORT:  if (rpt_ready)      state_d = COLLECT;
            default:                     state_d = COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-class working counter and report register
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
        logic [CW-1:0] rpt_q, rpt_d;

        always_comb begin
            cnt_inc = cnt_q + CW'(hit[gi]);
            cnt_d   = cnt_q;
            if (release_rpt)  cnt_d = '0;
            else if (accept)  cnt_d = cnt_inc;
            // Report captures the count including the window's last sample
            rpt_d = rpt_q;
            if (accept && last) rpt_d = cnt_inc;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                rpt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                rpt_q <= rpt_d;
            end
        end

        assign rpt_flat[gi*CW +: CW] = rpt_q;
    end

    // ------------------------------------------------------------------
    // Sample counter and run tracking
    // ------------------------------------------------------------------
    always_comb begin
        smp_d       = smp_q;
        run_len_d   = run_len_q;
        run_class_d = run_class_q;
        run_alert_d = 1'b0;
        if (release_rpt) begin
            smp_d       = '0;
            run_len_d   = '0;
            run_class_d = 2'b00;
        end else if (accept) begin
            smp_d = smp_q + 1'b1;
            if (!legal) begin
                run_len_d   = '0;
                run_class_d = 2'b00;
            end else begin
                if (run_class_q == smp_class) begin
                    if (run_len_q != WIN_C) run_len_d = run_len_q + 1'b1;
                end else begin
                    run_len_d   = {{(CW-1){1'b0}}, 1'b1};
                    run_class_d = smp_class;
                end
                // Fire only on the transition into RUN_THRESH; a run that
                // already sits at the threshold (saturated) does not re-fire.
                run_alert_d = (run_len_d == RT_C) && (run_len_q != RT_C);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            smp_q       <= '0;
            run_len_q   <= '0;
            run_class_q <= 2'b00;
            run_alert_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            smp_q       <= smp_d;
            run_len_q   <= run_len_d;
            run_class_q <= run_class_d;
            run_alert_q <= run_alert_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == COLLECT);
    assign rpt_valid = (state_q == REPORT);
    assign rpt_eq    = rpt_flat[0*CW +: CW];
    assign rpt_gt    = rpt_flat[1*CW +: CW];
    assign rpt_lt    = rpt_flat[2*CW +: CW];
    assign rpt_err   = rpt_flat[3*CW +: CW];
    assign run_alert = run_alert_q;
    assign run_class = run_class_q;

endmodule
